// File: rtl/rv_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_gen_pkg : shared opcodes, enums and LFSR step for the instruction generator
// Revision   : 1.0
// ---------------------------------------------------------------------------
package rv_gen_pkg;

    localparam logic [6:0]  c_op_r      = 7'b0110011;
    localparam logic [6:0]  c_op_i      = 7'b0010011;
    localparam logic [6:0]  c_op_load   = 7'b0000011;
    localparam logic [31:0] c_nop       = 32'h00000013;
    localparam logic [31:0] c_lfsr_taps = 32'h80200003;

    typedef enum logic [1:0] {
        MODE_R    = 2'd0,
        MODE_I    = 2'd1,
        MODE_LOAD = 2'd2,
        MODE_MIX  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Right-shifting Galois step; the shifted-out bit folds the taps back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? c_lfsr_taps : 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_lfsr32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_lfsr32 : 32-bit Galois LFSR with seed load; zero seeds fall back to SEED
// Revision  : 1.0
// ---------------------------------------------------------------------------
module rv_lfsr32
    import rv_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd737
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_value == 32'd0) ? SEED : load_value;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_instr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_instr_gen : streams NOP warm-up then LFSR-driven RV32I words over valid/ready
// Revision     : 1.0
// ---------------------------------------------------------------------------
module rv_instr_gen
    import rv_gen_pkg::*;
#(
    parameter logic [31:0] SEED      = 32'd737,
    parameter int          NUM_INSTR = 100,
    parameter int          WARMUP    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic        seed_load,
    input  logic [31:0] seed,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [15:0] issued,
    output logic        done
);

    localparam logic [15:0] c_warmup_last = 16'(WARMUP - 1);
    localparam logic [15:0] c_run_last    = 16'(NUM_INSTR - 1);

    state_e      r_state;
    mode_e       r_mode;
    logic [15:0] r_cnt;
    logic [31:0] w_lfsr;
    logic        w_xfer;
    logic        w_advance;
    logic        w_seed_load;

    assign w_xfer      = instr_valid && instr_ready;
    assign w_advance   = (r_state == ST_RUN) && w_xfer;
    assign w_seed_load = (r_state == ST_IDLE) && seed_load;

    rv_lfsr32 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_seed_load),
        .load_value(seed),
        .advance   (w_advance),
        .state     (w_lfsr)
    );

    function automatic logic [31:0] encode(input logic [31:0] s, input mode_e m);
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic [31:0] word;
        mode_e       cls;
        rd   = s[4:0];
        rs1  = s[9:5];
        rs2  = s[14:10];
        f3   = s[17:15];
        imm  = s[29:18];
        cls  = m;
        if (m == MODE_MIX) begin
            cls = (s[31:30] == 2'd2) ? MODE_I :
                  (s[31:30] == 2'd3) ? MODE_LOAD : MODE_R;
        end
        case (cls)
            MODE_I: begin
                // Shift immediates only carry shamt, plus bit 10 for SRAI.
                if (f3 == 3'd1) imm = imm & 12'h01F;
                if (f3 == 3'd5) imm = imm & 12'h41F;
                word = {imm, rs1, f3, rd, c_op_i};
            end
            MODE_LOAD: begin
                word = {imm, rs1, f3 & 3'b100, rd, c_op_load};
            end
            default: begin
                f7   = (s[29] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'b0100000 : 7'b0000000;
                word = {f7, rs2, rs1, f3, rd, c_op_r};
            end
        endcase
        return word;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_R;
            r_cnt       <= 16'd0;
            issued      <= 16'd0;
            done        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= c_nop;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_mode      <= mode_e'(mode);
                        r_cnt       <= 16'd0;
                        issued      <= 16'd0;
                        instr_valid <= 1'b1;
                        if (WARMUP == 0) begin
                            r_state <= ST_RUN;
                            instr   <= encode(w_lfsr, mode_e'(mode));
                        end else begin
                            r_state <= ST_WARMUP;
                            instr   <= c_nop;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (w_xfer) begin
                        if (r_cnt == c_warmup_last) begin
                            r_state <= ST_RUN;
                            r_cnt   <= 16'd0;
                            instr   <= encode(w_lfsr, r_mode);
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        if (issued != 16'hFFFF) issued <= issued + 16'd1;
                        if (r_cnt == c_run_last) begin
                            r_state     <= ST_DONE;
                            instr_valid <= 1'b0;
                            done        <= 1'b1;
                            instr       <= c_nop;
                        end else begin
                            // Word for the state the LFSR steps to on this same edge.
                            r_cnt <= r_cnt + 16'd1;
                            instr <= encode(lfsr_step(w_lfsr), r_mode);
                        end
                    end
                end
                ST_DONE: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        done    <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rv_instr_gen : scoreboard bench for rv_instr_gen
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_rv_instr_gen;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [1:0]  mode;
    logic        seed_load;
    logic [31:0] seed;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] issued;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl_s;
    int          prop_mode = 0;

    always #5 clk = ~clk;

    rv_instr_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed       (seed),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .issued     (issued),
        .done       (done)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] s, input logic [1:0] m);
        logic [1:0]  cls;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] w;
        f3  = s[17:15];
        imm = s[29:18];
        cls = m;
        if (m == 2'd3) begin
            case (s[31:30])
                2'd2:    cls = 2'd1;
                2'd3:    cls = 2'd2;
                default: cls = 2'd0;
            endcase
        end
        w = 32'd0;
        w[11:7]  = s[4:0];
        w[19:15] = s[9:5];
        if (cls == 2'd0) begin
            w[6:0]   = 7'b0110011;
            w[14:12] = f3;
            w[24:20] = s[14:10];
            if (s[29] && (f3 == 3'd0 || f3 == 3'd5)) w[30] = 1'b1;
        end else if (cls == 2'd1) begin
            w[6:0]   = 7'b0010011;
            w[14:12] = f3;
            if (f3 == 3'd1)      w[31:20] = {7'd0, imm[4:0]};
            else if (f3 == 3'd5) w[31:20] = {1'b0, imm[10], 5'd0, imm[4:0]};
            else                 w[31:20] = imm;
        end else begin
            w[6:0]   = 7'b0000011;
            w[14]    = f3[2];
            w[31:20] = imm;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each accepted word is popped and compared against the queue.
    always @(negedge clk) begin
        if (reset_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", instr, 32'hxxxxxxxx);
            end else begin
                check("instr_word", instr, exp_q.pop_front());
            end
            if (prop_mode == 1 && instr[6:0] == 7'b0010011 && instr[14:12] == 3'd1)
                check("slli_upper_zero", {25'd0, instr[31:25]}, 32'd0);
            if (prop_mode == 1 && instr[6:0] == 7'b0010011 && instr[14:12] == 3'd5)
                check("srxi_upper_zero", {26'd0, instr[31], instr[29:25]}, 32'd0);
            if (prop_mode == 2 && instr != NOP)
                check("load_shape", {23'd0, instr[6:0], instr[13:12]}, {23'd0, 7'b0000011, 2'b00});
        end
    end

    task automatic expect_run(input logic [1:0] m, input logic hand);
        exp_q.push_back(NOP);
        exp_q.push_back(NOP);
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(enc(mdl_s, m));
            mdl_s = step(mdl_s);
        end
        if (hand) begin
            exp_q[2] = 32'h000B80B3;
            exp_q[3] = 32'h000589B3;
        end
    endtask

    task automatic load_seed(input logic [31:0] v);
        seed      = v;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [1:0] m_after);
        mode = m;
        en   = 1'b1;
        tick();
        en   = 1'b0;
        mode = m_after;
        check("start_valid", {31'd0, instr_valid}, 32'd1);
        check("start_nop", instr, NOP);
        check("start_issued_clear", {16'd0, issued}, 32'd0);
    endtask

    task automatic finish_run();
        int k;
        k = 0;
        while (!done && k < 1000) begin
            tick();
            k++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
        check("issued_final", {16'd0, issued}, 32'd100);
        check("valid_low_done", {31'd0, instr_valid}, 32'd0);
        tick();
        check("done_cleared", {31'd0, done}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic wait_issued(input logic [15:0] n);
        int k;
        k = 0;
        while (issued != n && k < 1000) begin
            tick();
            k++;
        end
        check("wait_issued", {16'd0, issued}, {16'd0, n});
    endtask

    initial begin
        reset_n     = 1'b0;
        en          = 1'b0;
        mode        = 2'd0;
        seed_load   = 1'b0;
        seed        = 32'd0;
        instr_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_issued", {16'd0, issued}, 32'd0);
        check("rst_instr", instr, NOP);
        reset_n = 1'b1;
        tick();

        // R-type run straight out of reset
        mdl_s = 32'd737;
        expect_run(2'd0, 1'b1);
        start_run(2'd0, 2'd0);
        finish_run();

        // Zero seed falls back to 737; seed_load mid-run must be ignored
        load_seed(32'd0);
        mdl_s = 32'd737;
        expect_run(2'd0, 1'b1);
        start_run(2'd0, 2'd0);
        repeat (20) tick();
        seed      = 32'h12345678;
        seed_load = 1'b1;
        repeat (3) tick();
        seed_load = 1'b0;
        finish_run();

        // I-type run; mode change after start is ignored
        load_seed(32'h1234ABCD);
        mdl_s     = 32'h1234ABCD;
        prop_mode = 1;
        expect_run(2'd1, 1'b0);
        start_run(2'd1, 2'd2);
        finish_run();

        // Load run continuing from the previous LFSR state
        prop_mode = 2;
        expect_run(2'd2, 1'b0);
        start_run(2'd2, 2'd0);
        finish_run();
        prop_mode = 0;

        // Mixed run
        load_seed(32'hDEADBEEF);
        mdl_s = 32'hDEADBEEF;
        expect_run(2'd3, 1'b0);
        start_run(2'd3, 2'd1);
        finish_run();

        // Back-pressure mid-run
        load_seed(32'hCAFEF00D);
        mdl_s = 32'hCAFEF00D;
        expect_run(2'd0, 1'b0);
        start_run(2'd0, 2'd0);
        wait_issued(16'd10);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", instr, exp_q[0]);
            check("stall_issued", {16'd0, issued}, 32'd10);
        end
        instr_ready = 1'b1;
        tick();
        check("stall_release_issued", {16'd0, issued}, 32'd11);
        finish_run();

        // Reset with a pending handshake
        expect_run(2'd0, 1'b0);
        start_run(2'd0, 2'd0);
        wait_issued(16'd5);
        instr_ready = 1'b0;
        reset_n     = 1'b0;
        tick();
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_issued", {16'd0, issued}, 32'd0);
        check("midrst_instr", instr, NOP);
        check("midrst_done", {31'd0, done}, 32'd0);
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        exp_q.delete();
        tick();

        // LFSR is back at 737 after reset
        mdl_s = 32'd737;
        expect_run(2'd0, 1'b1);
        start_run(2'd0, 2'd0);
        finish_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_instr_gen.md
RV_INSTR_GEN -- requirements
Module: rv_instr_gen

Interface
REQ-001 Parameter SEED, default 32'd737, LFSR value after reset and replacement for any zero seed.
REQ-002 Parameter NUM_INSTR, default 100, number of random instructions issued per run.
REQ-003 Parameter WARMUP, default 2, number of NOPs issued before random instructions.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 en  input  1  start request, sampled only in IDLE.
REQ-007 mode  input  2  instruction class: 0 R-type ALU, 1 I-type ALU, 2 load, 3 mixed.
REQ-008 seed_load  input  1  load seed into LFSR, honoured only in IDLE.
REQ-009 seed  input  32  seed value.
REQ-010 instr_valid  output  1  instr holds a valid instruction word.
REQ-011 instr_ready  input  1  consumer (core imem response path) accepts instr.
REQ-012 instr  output  32  instruction word, registered.
REQ-013 issued  output  16  count of accepted random (non-NOP) instructions.
REQ-014 done  output  1  high in DONE state.

Function
REQ-015 FSM states: IDLE, WARMUP, RUN, DONE.
- IDLE->WARMUP on en.
- WARMUP->RUN after WARMUP accepted NOPs; WARMUP=0 goes straight to RUN.
- RUN->DONE after NUM_INSTR accepts.
- DONE->IDLE on en=0.
REQ-016 instr_valid SHALL be high in WARMUP and RUN only, first asserted the cycle after en is sampled.
REQ-017 Transfer occurs on instr_valid && instr_ready; while instr_valid && !instr_ready, instr and LFSR SHALL hold.
REQ-018 WARMUP instr SHALL be 32'h00000013.
REQ-019 LFSR: 32-bit Galois, taps 32'h80200003, advanced exactly once per accepted RUN transfer; instr is a function of the current state S.
REQ-020 Fields: rd=S[4:0], rs1=S[9:5], rs2=S[14:10], f3=S[17:15], imm=S[29:18].
REQ-021 R-type: opcode 7'b0110011; funct7=7'b0100000 when S[29] && f3 in {0,5}, else 0.
REQ-022 I-ALU: opcode 7'b0010011.
- f3==1: imm masked by 12'h01F.
- f3==5: imm masked by 12'h41F.
- Other f3: imm unmasked.
REQ-023 Load: opcode 7'b0000011; f3 masked by 3'b100 (LB/LBU only).
REQ-024 Mixed class from S[31:30]: 0,1 R-type; 2 I-ALU; 3 load.
REQ-025 mode SHALL be sampled with en into a register; later mode changes are ignored until the next run.
REQ-026 seed_load in IDLE SHALL load seed, or SEED if seed==0; seed_load outside IDLE SHALL be ignored.
REQ-027 issued SHALL increment per accepted RUN transfer, SHALL saturate at 16'hFFFF, and SHALL clear on IDLE->WARMUP.
REQ-028 rd/rs1/rs2 = x0 SHALL be permitted.

Reset
REQ-029 reset_n=0 at a clock edge SHALL force, regardless of state or a pending handshake:
- IDLE;
- LFSR=SEED;
- issued=0, done=0, instr_valid=0;
- instr=32'h00000013.

Structure
REQ-030 A shared package rv_gen_pkg SHALL hold the opcode constants, the NOP constant, the mode and FSM-state enums, and the LFSR tap constant.
REQ-031 A sub-module rv_lfsr32 (load, advance, state) SHALL contain the LFSR; encoding and the FSM stay in rv_instr_gen.

Verification
REQ-032 Reset, en=1, mode=0, ready=1 -> 2 NOPs 0x00000013, then 100 words with opcode 0110011, then done=1, issued=100.
REQ-033 seed_load=1, seed=0 in IDLE -> LFSR=737; repeat run with seed 737 -> identical instr sequence.
REQ-034 mode=1, ready=1 for 100 issues -> every word with f3==1 has instr[31:25]==0, and every word with f3==5 has instr[29:25]==0 and instr[31]==0.
REQ-035 mode=2 -> every word has opcode 0000011 and instr[13:12]==0.
REQ-036 ready held low 5 cycles mid-RUN -> instr unchanged and issued unchanged until ready=1, then exactly one increment.
REQ-037 reset_n=0 mid-RUN with a transfer pending -> next cycle instr_valid=0, issued=0, LFSR=737.
